// File: rtl/bht_predictor.sv
// Branch history table predictor: 2-bit saturating counters, gshare or bimodal
// indexing, one-cycle lookup, multi-slot in-order updates and global history.
module bht_predictor #(
  parameter int ISSUE_W   = 2,
  parameter int ENTRIES   = 64,
  parameter int HIST_BITS = 6,
  parameter int GSHARE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [ISSUE_W-1:0]            lookup_valid,
  input  logic [32*ISSUE_W-1:0]         lookup_pc,
  output logic [ISSUE_W-1:0]            predict_taken,
  output logic [ISSUE_W-1:0]            predict_valid,
  output logic [HIST_BITS-1:0]          predict_hist,
  input  logic [ISSUE_W-1:0]            upd_valid,
  input  logic [32*ISSUE_W-1:0]         upd_pc,
  input  logic [HIST_BITS*ISSUE_W-1:0]  upd_hist,
  input  logic [ISSUE_W-1:0]            upd_taken,
  input  logic [ISSUE_W-1:0]            upd_mispredict,
  output logic [HIST_BITS-1:0]          ghr,
  output logic [15:0]                   mispredict_count
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int CW  = $clog2(ISSUE_W + 1);

  function automatic logic [IDX-1:0] tableIdx(input logic [31:0] pc,
                                               input logic [HIST_BITS-1:0] hist);
    logic [IDX-1:0] h;
    h = (GSHARE != 0) ? IDX'(hist) : '0;
    return pc[IDX+1:2] ^ h;
  endfunction

  function automatic logic [1:0] satCount(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [CW-1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0]           cntTable [ENTRIES];
  logic [1:0]           cntNext  [ENTRIES];
  logic [HIST_BITS-1:0] ghrReg, ghrNext;
  logic [15:0]          missCnt;
  logic [CW-1:0]        missInc;
  logic [IDX-1:0]       uIdx, lIdx;
  logic [ISSUE_W-1:0]   takeNext;
  logic [ISSUE_W-1:0]   vld_p1, predTaken_p1;
  logic [HIST_BITS-1:0] predHist_p1;
  logic                 unusedPcBits;

  // PC bits outside the index field never reach the table.
  assign unusedPcBits = ^{lookup_pc, upd_pc, upd_hist};

  // Lookup reads the registered table, so same-cycle updates are not visible.
  always_comb begin
    takeNext = '0;
    lIdx     = '0;
    for (int s = 0; s < ISSUE_W; s++) begin
      lIdx        = tableIdx(lookup_pc[32*s +: 32], ghrReg);
      takeNext[s] = lookup_valid[s] & cntTable[lIdx][1];
    end
  end

  // Slots apply in order so colliding updates saturate step by step.
  always_comb begin
    cntNext = cntTable;
    ghrNext = ghrReg;
    missInc = '0;
    uIdx    = '0;
    for (int s = 0; s < ISSUE_W; s++) begin
      if (upd_valid[s]) begin
        uIdx          = tableIdx(upd_pc[32*s +: 32], upd_hist[HIST_BITS*s +: HIST_BITS]);
        cntNext[uIdx] = satCount(cntNext[uIdx], upd_taken[s]);
        ghrNext       = (ghrNext << 1) | HIST_BITS'(upd_taken[s]);
        if (upd_mispredict[s]) missInc = missInc + CW'(1);
      end
    end
  end

  // Stage p1: registered predictions and architectural state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < ENTRIES; e++) cntTable[e] <= 2'b01;
      ghrReg       <= '0;
      missCnt      <= '0;
      vld_p1       <= '0;
      predTaken_p1 <= '0;
      predHist_p1  <= '0;
    end else begin
      cntTable <= cntNext;
      ghrReg   <= ghrNext;
      missCnt  <= satAdd(missCnt, missInc);
      if (flush) begin
        vld_p1       <= '0;
        predTaken_p1 <= '0;
      end else if (!stall) begin
        vld_p1       <= lookup_valid;
        predTaken_p1 <= takeNext;
        predHist_p1  <= ghrReg;
      end
    end
  end

  assign predict_valid    = vld_p1;
  assign predict_taken    = predTaken_p1;
  assign predict_hist     = predHist_p1;
  assign ghr              = ghrReg;
  assign mispredict_count = missCnt;
endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: bimodal and gshare instances against a reference
// model scoreboard, plus hand-computed vectors and reset/saturation sequences.
module tb_bht_predictor;
  localparam int NE = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [1:0]  lv, uv, ut, um;
  logic [63:0] lpc, upc;
  logic [11:0] uh;

  logic [1:0]  pTakenB, pValidB, pTakenG, pValidG;
  logic [5:0]  pHistB, pHistG, ghrB, ghrG;
  logic [15:0] cntB, cntG;

  bht_predictor #(.ISSUE_W(2), .ENTRIES(64), .HIST_BITS(6), .GSHARE(0)) dutB (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .lookup_valid(lv), .lookup_pc(lpc),
    .predict_taken(pTakenB), .predict_valid(pValidB), .predict_hist(pHistB),
    .upd_valid(uv), .upd_pc(upc), .upd_hist(uh), .upd_taken(ut),
    .upd_mispredict(um), .ghr(ghrB), .mispredict_count(cntB));

  bht_predictor #(.ISSUE_W(2), .ENTRIES(64), .HIST_BITS(6), .GSHARE(1)) dutG (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .lookup_valid(lv), .lookup_pc(lpc),
    .predict_taken(pTakenG), .predict_valid(pValidG), .predict_hist(pHistG),
    .upd_valid(uv), .upd_pc(upc), .upd_hist(uh), .upd_taken(ut),
    .upd_mispredict(um), .ghr(ghrG), .mispredict_count(cntG));

  typedef struct packed {
    logic [1:0]  vB, tB, vG, tG;
    logic [5:0]  h, g;
    logic [15:0] c;
  } exp_t;

  typedef struct {
    logic [1:0]  lv;
    logic [31:0] p0, p1;
    logic [1:0]  uv;
    logic [31:0] u0, u1;
    logic [1:0]  ut, um;
    logic        st, fl;
    logic [1:0]  eV, eT;
    logic [5:0]  eG;
    logic [15:0] eC;
  } vec_t;

  exp_t        sbQ[$];
  exp_t        mPred;
  logic [1:0]  mtB[NE];
  logic [1:0]  mtG[NE];
  logic [5:0]  mGhr;
  logic [15:0] mCnt;
  int          passCnt = 0;
  int          totalCnt = 0;
  vec_t        vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int idxOf(input logic [31:0] pc, input logic [5:0] h, input bit gs);
    logic [5:0] i;
    i = pc[7:2];
    if (gs) i = i ^ h;
    return int'(i);
  endfunction

  function automatic logic [1:0] bump(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic modelReset();
    for (int e = 0; e < NE; e++) begin
      mtB[e] = 2'b01;
      mtG[e] = 2'b01;
    end
    mGhr  = '0;
    mCnt  = '0;
    mPred = '0;
    sbQ.delete();
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0;
    lv = '0; lpc = '0; uv = '0; upc = '0; uh = '0; ut = '0; um = '0;
  endtask

  // Reference behaviour for one clock edge with the currently driven inputs.
  task automatic modelStep();
    exp_t e;
    int   iB, iG;
    e = mPred;
    if (flush) begin
      e.vB = '0; e.tB = '0; e.vG = '0; e.tG = '0;
    end else if (!stall) begin
      for (int s = 0; s < 2; s++) begin
        e.vB[s] = lv[s];
        e.vG[s] = lv[s];
        e.tB[s] = lv[s] & mtB[idxOf(lpc[32*s +: 32], mGhr, 1'b0)][1];
        e.tG[s] = lv[s] & mtG[idxOf(lpc[32*s +: 32], mGhr, 1'b1)][1];
      end
      e.h = mGhr;
    end
    for (int s = 0; s < 2; s++) begin
      if (uv[s]) begin
        iB = idxOf(upc[32*s +: 32], uh[6*s +: 6], 1'b0);
        iG = idxOf(upc[32*s +: 32], uh[6*s +: 6], 1'b1);
        mtB[iB] = bump(mtB[iB], ut[s]);
        mtG[iG] = bump(mtG[iG], ut[s]);
        mGhr = {mGhr[4:0], ut[s]};
        if (um[s] && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      end
    end
    e.g = mGhr;
    e.c = mCnt;
    mPred = e;
    sbQ.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    modelStep();
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    chk("validB", 32'(pValidB), 32'(e.vB));
    chk("takenB", 32'(pTakenB), 32'(e.tB));
    chk("validG", 32'(pValidG), 32'(e.vG));
    chk("takenG", 32'(pTakenG), 32'(e.tG));
    chk("histB",  32'(pHistB),  32'(e.h));
    chk("histG",  32'(pHistG),  32'(e.h));
    chk("ghrB",   32'(ghrB),    32'(e.g));
    chk("ghrG",   32'(ghrG),    32'(e.g));
    chk("cntB",   32'(cntB),    32'(e.c));
    chk("cntG",   32'(cntG),    32'(e.c));
  endtask

  task automatic checkTablesReset(input string name);
    int bad;
    bad = 0;
    for (int e = 0; e < NE; e++) begin
      if (dutB.cntTable[e] !== 2'b01) bad++;
      if (dutG.cntTable[e] !== 2'b01) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic doReset();
    idle();
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] pickPc();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0040;
      1: return 32'h0000_0080;
      2: return 32'h0000_0100;
      3: return 32'h0000_01FC;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pValidB), 32'd0);
    chk("rst_taken", 32'(pTakenB), 32'd0);
    chk("rst_hist",  32'(pHistB),  32'd0);
    chk("rst_ghr",   32'(ghrB),    32'd0);
    chk("rst_cnt",   32'(cntB),    32'd0);
    checkTablesReset("rst_table");
    rst = 1'b1;

    //        lv     p0        p1        uv     u0        u1        ut     um     st    fl    eV     eT     eG         eC
    vt[0] = '{2'b01, 32'h40, 32'h00, 2'b00, 32'h00, 32'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 6'b000000, 16'd0};
    vt[1] = '{2'b00, 32'h00, 32'h00, 2'b01, 32'h40, 32'h00, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 6'b000001, 16'd1};
    vt[2] = '{2'b01, 32'h40, 32'h00, 2'b01, 32'h40, 32'h00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 6'b000011, 16'd1};
    vt[3] = '{2'b10, 32'h00, 32'h40, 2'b01, 32'h40, 32'h00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 6'b000111, 16'd1};
    vt[4] = '{2'b01, 32'h40, 32'h00, 2'b01, 32'h40, 32'h00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 6'b001110, 16'd2};
    vt[5] = '{2'b11, 32'h40, 32'h80, 2'b00, 32'h00, 32'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b01, 6'b001110, 16'd2};
    vt[6] = '{2'b00, 32'h00, 32'h00, 2'b11, 32'h80, 32'h80, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 6'b111011, 16'd4};
    vt[7] = '{2'b10, 32'h00, 32'h80, 2'b11, 32'h80, 32'h80, 2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 6'b101110, 16'd4};
    vt[8] = '{2'b01, 32'h80, 32'h00, 2'b00, 32'h00, 32'h00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10, 6'b101110, 16'd4};
    vt[9] = '{2'b01, 32'h40, 32'h00, 2'b00, 32'h00, 32'h00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 6'b101110, 16'd4};

    for (int i = 0; i < 10; i++) begin
      lv = vt[i].lv; lpc = {vt[i].p1, vt[i].p0};
      uv = vt[i].uv; upc = {vt[i].u1, vt[i].u0}; uh = '0;
      ut = vt[i].ut; um = vt[i].um; stall = vt[i].st; flush = vt[i].fl;
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(pValidB), 32'(vt[i].eV));
      chk($sformatf("vec%0d_taken", i), 32'(pTakenB), 32'(vt[i].eT));
      chk($sformatf("vec%0d_ghr", i),   32'(ghrB),    32'(vt[i].eG));
      chk($sformatf("vec%0d_cnt", i),   32'(cntB),    32'(vt[i].eC));
    end

    // Two same-index taken updates in one cycle from reset.
    doReset();
    uv = 2'b11; upc = {32'h100, 32'h100}; ut = 2'b11;
    cycle();
    chk("dual_ghr", 32'(ghrB), 32'h03);
    idle();
    lv = 2'b01; lpc = {32'h0, 32'h100};
    cycle();
    chk("dual_taken", 32'(pTakenB), 32'h1);

    // Stall held for three cycles while the lookup PC changes.
    idle();
    lv = 2'b11; lpc = {32'h80, 32'h100};
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv = 2'(i); lpc = {32'(i * 4), 32'h40 + 32'(i * 8)};
      cycle();
    end
    flush = 1'b1;
    cycle();
    chk("flush_valid", 32'(pValidB), 32'd0);
    idle();

    // Randomised traffic with frequent index collisions.
    for (int i = 0; i < 400; i++) begin
      lv = 2'($urandom_range(0, 3));
      lpc = {pickPc(), pickPc()};
      uv = 2'($urandom_range(0, 3));
      upc = {pickPc(), pickPc()};
      uh = 12'($urandom);
      ut = 2'($urandom_range(0, 3));
      um = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Mispredict counter saturation: two per cycle from zero.
    doReset();
    uv = 2'b11; um = 2'b11;
    for (int i = 0; i < 32767; i++) begin
      upc = {pickPc(), pickPc()};
      ut = 2'($urandom_range(0, 3));
      cycle();
    end
    chk("cnt_fffe", 32'(cntB), 32'hFFFE);
    cycle();
    chk("cnt_sat", 32'(cntB), 32'hFFFF);
    repeat (3) cycle();
    chk("cnt_hold", 32'(cntB), 32'hFFFF);

    // Reset asserted between edges while updates are being driven.
    upc = {32'h40, 32'h40}; ut = 2'b11; lv = 2'b01; lpc = {32'h0, 32'h40};
    #3;
    rst = 1'b0;
    #1;
    chk("async_cnt",   32'(cntB),    32'd0);
    chk("async_ghr",   32'(ghrB),    32'd0);
    chk("async_valid", 32'(pValidB), 32'd0);
    checkTablesReset("async_table");
    modelReset();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    lv = 2'b01; lpc = {32'h0, 32'h40};
    cycle();
    chk("post_rst_valid", 32'(pValidB), 32'h1);
    chk("post_rst_taken", 32'(pTakenB), 32'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
